// File: rtl/cdac_ld_arb_if.sv
// cdac_ld_arb_if: local-loader, JTAG and DAC pin bundle for cdac_ld_arb.
// slave = arbiter side, master = requesters/pins side.
interface cdac_ld_arb_if #(
  parameter int DAC_BITS = 12
);
  logic                LD_REQ;
  logic [DAC_BITS-1:0] LD_DATA;
  logic                LD_BUSY;
  logic                LD_DONE;
  logic                JREQ;
  logic                J_DACCLK;
  logic                J_DACDAT;
  logic                J_ENB_B;
  logic                JGNT;
  logic                CNT_CLR;
  logic [7:0]          JDENY_CNT;
  logic                DACCLK;
  logic                DACDAT;
  logic                DAC_ENB_B;

  modport slave (
    input  LD_REQ, LD_DATA, JREQ,
    input  J_DACCLK, J_DACDAT, J_ENB_B,
    input  CNT_CLR,
    output LD_BUSY, LD_DONE, JGNT, JDENY_CNT,
    output DACCLK, DACDAT, DAC_ENB_B
  );

  modport master (
    output LD_REQ, LD_DATA, JREQ,
    output J_DACCLK, J_DACDAT, J_ENB_B,
    output CNT_CLR,
    input  LD_BUSY, LD_DONE, JGNT, JDENY_CNT,
    input  DACCLK, DACDAT, DAC_ENB_B
  );
endinterface

// File: rtl/cdac_ld_arb.sv
// cdac_ld_arb: shares the comparator-DAC serial port between JTAG and a local loader.
// Ports: CLK25, RST_B (async, active low), bus (cdac_ld_arb_if.slave).
// Optional: CDAC_AUTO_REFRESH_EN re-sends the last local word every REFRESH_CYC.
module cdac_ld_arb #(
  parameter int DAC_BITS    = 12,
  parameter int CLK_DIV     = 2,
  parameter int REFRESH_CYC = 1048576
) (
  input logic           CLK25,
  input logic           RST_B,
  cdac_ld_arb_if.slave  bus
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DAC_BITS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DAC_BITS - 1);

  if (CLK_DIV < 1 || REFRESH_CYC < 1) begin : g_bad_param
    $error("cdac_ld_arb: CLK_DIV and REFRESH_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_JTAG, S_SETUP, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       div_q;
  logic [BW-1:0]       bit_q;
  logic                ph_q;
  logic [DAC_BITS-1:0] sh_q;
  logic [DAC_BITS-1:0] sh_nx;
  logic                clk_q, dat_q, enb_q;
  logic                busy_q, done_q, gnt_q, loc_q;
  logic                jreq_m_q, jreq_s_q, jreq_p_q;
  logic [7:0]          deny_q;
  logic                div_end, jrise, in_frame;

  assign sh_nx    = sh_q << 1;
  assign div_end  = (div_q == DIV_LAST);
  assign jrise    = jreq_s_q & ~jreq_p_q;
  assign in_frame = (state_q != S_IDLE) && (state_q != S_JTAG);

`ifdef CDAC_AUTO_REFRESH_EN
  logic [DAC_BITS-1:0] word_q, keep_q;
  logic                valid_q, pend_q;
  logic [31:0]         refr_q;
  logic                expire;
  // Expiry is seen one cycle early so the frame starts exactly on time.
  assign expire = pend_q | (refr_q == 32'd1);
`endif

  always_ff @(posedge CLK25 or negedge RST_B) begin
    if (!RST_B) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ph_q     <= 1'b0;
      sh_q     <= '0;
      clk_q    <= 1'b0;
      dat_q    <= 1'b0;
      enb_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gnt_q    <= 1'b0;
      loc_q    <= 1'b0;
      jreq_m_q <= 1'b0;
      jreq_s_q <= 1'b0;
      jreq_p_q <= 1'b0;
      deny_q   <= '0;
`ifdef CDAC_AUTO_REFRESH_EN
      word_q   <= '0;
      keep_q   <= '0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      refr_q   <= 32'(REFRESH_CYC);
`endif
    end else begin
      jreq_m_q <= bus.JREQ;
      jreq_s_q <= jreq_m_q;
      jreq_p_q <= jreq_s_q;
      done_q   <= 1'b0;

      if (bus.CNT_CLR)
        deny_q <= '0;
      else if (jrise && in_frame && deny_q != 8'hFF)
        deny_q <= deny_q + 8'd1;

`ifdef CDAC_AUTO_REFRESH_EN
      if (refr_q != 32'd0)
        refr_q <= refr_q - 32'd1;
      if (expire)
        pend_q <= 1'b1;
`endif

      unique case (state_q)
        S_IDLE: begin
          div_q <= '0;
          bit_q <= '0;
          ph_q  <= 1'b0;
          if (jreq_s_q) begin
            state_q <= S_JTAG;
            gnt_q   <= 1'b1;
          end else if (bus.LD_REQ) begin
            state_q <= S_SETUP;
            sh_q    <= bus.LD_DATA;
            dat_q   <= bus.LD_DATA[DAC_BITS-1];
            enb_q   <= 1'b0;
            busy_q  <= 1'b1;
            loc_q   <= 1'b1;
`ifdef CDAC_AUTO_REFRESH_EN
            word_q  <= bus.LD_DATA;
          end else if (expire && valid_q) begin
            state_q <= S_SETUP;
            sh_q    <= keep_q;
            dat_q   <= keep_q[DAC_BITS-1];
            enb_q   <= 1'b0;
            busy_q  <= 1'b1;
            loc_q   <= 1'b0;
            pend_q  <= 1'b0;
`endif
          end
        end
        S_JTAG: begin
          if (!jreq_s_q) begin
            state_q <= S_GAP;
            gnt_q   <= 1'b0;
          end
        end
        S_SETUP: begin
          if (div_end) begin
            div_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        S_SHIFT: begin
          if (div_end) begin
            div_q <= '0;
            if (!ph_q) begin
              ph_q  <= 1'b1;
              clk_q <= 1'b1;
            end else begin
              ph_q  <= 1'b0;
              clk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= S_HOLD;
              end else begin
                bit_q <= bit_q + BW'(1);
                sh_q  <= sh_nx;
                dat_q <= sh_nx[DAC_BITS-1];
              end
            end
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (div_end) begin
            div_q   <= '0;
            state_q <= S_GAP;
            enb_q   <= 1'b1;
            dat_q   <= 1'b0;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        S_GAP: begin
          if (div_end) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= loc_q;
            loc_q   <= 1'b0;
`ifdef CDAC_AUTO_REFRESH_EN
            // Only loader frames restart the timer; a JTAG gap does not.
            if (busy_q) begin
              refr_q <= 32'(REFRESH_CYC);
              pend_q <= 1'b0;
            end
            if (loc_q) begin
              keep_q  <= word_q;
              valid_q <= 1'b1;
            end
`endif
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // JTAG drives the pins straight through; it runs on its own clock.
  assign bus.JGNT      = gnt_q;
  assign bus.DACCLK    = gnt_q ? bus.J_DACCLK : clk_q;
  assign bus.DACDAT    = gnt_q ? bus.J_DACDAT : dat_q;
  assign bus.DAC_ENB_B = gnt_q ? bus.J_ENB_B  : enb_q;
  assign bus.LD_BUSY   = busy_q;
  assign bus.LD_DONE   = done_q;
  assign bus.JDENY_CNT = deny_q;

endmodule
